// File: rtl/mips_pipe_pkg.sv
// Shared types and codes for the 5-stage MIPS pipeline control blocks.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MD_BUSY    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Forwarding mux select codes shared with the forwarding unit.
    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_LW    = 2'b11;

endpackage

// File: rtl/muldiv_busy_counter.sv
// Down-counter tracking the remaining cycles a mul/div occupies EX; holds at zero.
module muldiv_busy_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ID-stage stall/flush sequencer: load-use stalls, mul/div busy interlock and taken-branch flush.
module pipeline_hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_memRead,
    input  logic [REG_W-1:0] ID_EX_rt,
    input  logic [REG_W-1:0] IF_ID_rs,
    input  logic [REG_W-1:0] IF_ID_rt,
    input  logic             IF_ID_usesRt,
    input  logic             ID_isMulDiv,
    input  logic             ID_readsHiLo,
    input  logic             EX_branchTaken,
    output logic             pcWrite,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             mdBusy,
    output logic [1:0]       o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_md_cnt
);

    hz_state_t        r_state, w_state_nxt;
    logic             r_ld_pend, w_ld_pend_nxt;
    logic             w_load_use, w_ld_use_eff, w_md_busy, w_md_hazard;
    logic             w_stall, w_issue, w_md_zero;
    logic [CNT_W-1:0] w_md_cnt;

    assign w_load_use = ID_EX_memRead && (ID_EX_rt != REG_W'(REG_ZERO)) &&
                        ((ID_EX_rt == IF_ID_rs) || (IF_ID_usesRt && (ID_EX_rt == IF_ID_rt)));
    assign w_md_busy   = (r_state == MD_BUSY);
    assign w_md_hazard = w_md_busy && (ID_isMulDiv || ID_readsHiLo);
    // The cycle after a load-use stall the load sits in MEM/WB and forwarding covers it.
    assign w_ld_use_eff = w_load_use && ((r_state == RUN) || (w_md_busy && !r_ld_pend));
    assign w_stall      = w_ld_use_eff || w_md_hazard;
    assign w_issue      = ID_isMulDiv && !EX_branchTaken && !w_stall && !w_md_busy;

    muldiv_busy_counter #(.CNT_W(CNT_W)) u_md_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_issue),
        .i_load_val (CNT_W'(MULDIV_LAT - 1)),
        .i_dec      (w_md_busy),
        .o_cnt      (w_md_cnt),
        .o_zero     (w_md_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_ld_pend <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_pend <= w_ld_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ld_pend_nxt = 1'b0;
        case (r_state)
            RUN, LOAD_STALL: begin
                if (EX_branchTaken)    w_state_nxt = RUN;
                else if (w_ld_use_eff) w_state_nxt = LOAD_STALL;
                else if (w_issue)      w_state_nxt = MD_BUSY;
                else                   w_state_nxt = RUN;
            end
            MD_BUSY: begin
                // A branch never cancels an in-flight mul/div; only the count ends it.
                if (w_md_zero) begin
                    w_state_nxt = (!EX_branchTaken && w_ld_use_eff) ? LOAD_STALL : RUN;
                end else begin
                    w_state_nxt   = MD_BUSY;
                    w_ld_pend_nxt = !EX_branchTaken && w_ld_use_eff;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        pcWrite      = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        mdBusy       = w_md_busy;
        if (!rst_n) begin
            pcWrite      = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            mdBusy       = 1'b0;
        end else if (EX_branchTaken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else if (w_stall) begin
            pcWrite      = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end
    end

    assign o_dbg_state  = r_state;
    assign o_dbg_md_cnt = w_md_cnt;

endmodule
